// File: rtl/gpu_ci_arb_pkg.sv
// gpu_ci_arb_pkg
//   Shared types and constants for the GPU custom-instruction arbiter.
//   - arb_state_t      : arbiter FSM states
//   - GPU_OP_W         : opcode width on the GPU CI port
//   - GPU_DATA_W       : operand / response data width
//   - GPU_CI_ERR_DATA  : default response data returned when a command times out
//   - idx_width()      : width of a hart index, never less than one bit
package gpu_ci_arb_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ISSUE    = 2'd1,
      WAIT_RSP = 2'd2,
      RETURN   = 2'd3
   } arb_state_t;

   localparam int GPU_OP_W   = 8;
   localparam int GPU_DATA_W = 64;

   localparam logic [GPU_DATA_W-1:0] GPU_CI_ERR_DATA = 64'hDEAD_0BAD_DEAD_0BAD;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/gpu_ci_arbiter_rr_pick.sv
// gpu_ci_rr_pick
//   Combinational round-robin picker. Finds the first asserted request when
//   scanning rr_ptr, rr_ptr+1, ... wrapping modulo N_REQ.
//   Ports:
//     req    in  N_REQ   request vector
//     rr_ptr in  IDX_W   index that has highest priority this cycle
//     grant  out N_REQ   one-hot grant (all zero when no request)
//     idx    out IDX_W   index of the granted request (0 when none)
//     any    out 1       at least one request present
module gpu_ci_rr_pick
   import gpu_ci_arb_pkg::*;
#(
   parameter  int N_REQ = 4,
   localparam int IDX_W = idx_width(N_REQ)
)(
   input  logic [N_REQ-1:0] req,
   input  logic [IDX_W-1:0] rr_ptr,
   output logic [N_REQ-1:0] grant,
   output logic [IDX_W-1:0] idx,
   output logic             any
);

   // Requests at or above the pointer win over the wrapped-around ones.
   logic [N_REQ-1:0] upper_req;
   logic [N_REQ-1:0] scan_req;

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_upper
      assign upper_req[gi] = req[gi] && (rr_ptr <= IDX_W'(gi));
   end

   // If nothing sits at/above the pointer, every requester is below it, so the
   // lowest one of the full vector is the first reached after wrapping.
   assign scan_req = (|upper_req) ? upper_req : req;
   assign any      = |req;

   always_comb begin
      idx = '0;
      // Scan downwards so the lowest set bit is the last one written.
      for (int i = N_REQ - 1; i >= 0; i--) begin
         if (scan_req[i]) begin
            idx = IDX_W'(i);
         end
      end
   end

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant
      assign grant[gi] = any && (idx == IDX_W'(gi));
   end

endmodule

// File: rtl/gpu_ci_arbiter.sv
// gpu_ci_arbiter
//   Shares one GPU custom-instruction port among N_REQ harts. Round-robin grant,
//   one command outstanding at a time, response routed back to the issuing hart.
//   Optional feature macro: GPU_CI_ARB_TIMEOUT_EN -- when defined, a 16-bit wait
//   counter returns ERR_DATA after TIMEOUT_CYCLES in WAIT_RSP and sets the sticky
//   timeout_flag; when undefined, WAIT_RSP waits forever and timeout_flag is 0.
//   Ports:
//     clk, rst_n                    clock, asynchronous active-low reset
//     req_valid/op/arg0/arg1        per-hart command (hart i at slice i)
//     req_ready                     one-hot command accept (IDLE only)
//     req_rsp_valid/req_rsp_data    one-hot response to owner, shared data bus
//     req_rsp_ready                 per-hart response accept
//     gpu_ci_valid/op/arg0/arg1     latched command to the GPU
//     gpu_ci_ready                  GPU accepts command
//     gpu_ci_rsp_valid/data/ready   GPU response handshake
//     busy                          state != IDLE
//     owner                         index of the current / last owner
//     stale_cnt                     saturating count of discarded GPU responses
//     timeout_flag                  sticky timeout indication
module gpu_ci_arbiter
   import gpu_ci_arb_pkg::*;
#(
   parameter  int                    N_REQ          = 4,
   parameter  int                    TIMEOUT_CYCLES = 1024,
   parameter  logic [GPU_DATA_W-1:0] ERR_DATA       = GPU_CI_ERR_DATA,
   localparam int                    IDX_W          = idx_width(N_REQ)
)(
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [N_REQ-1:0]              req_valid,
   input  logic [GPU_OP_W*N_REQ-1:0]     req_op,
   input  logic [GPU_DATA_W*N_REQ-1:0]   req_arg0,
   input  logic [GPU_DATA_W*N_REQ-1:0]   req_arg1,
   output logic [N_REQ-1:0]              req_ready,
   output logic [N_REQ-1:0]              req_rsp_valid,
   output logic [GPU_DATA_W-1:0]         req_rsp_data,
   input  logic [N_REQ-1:0]              req_rsp_ready,
   output logic                          gpu_ci_valid,
   output logic [GPU_OP_W-1:0]           gpu_ci_op,
   output logic [GPU_DATA_W-1:0]         gpu_ci_arg0,
   output logic [GPU_DATA_W-1:0]         gpu_ci_arg1,
   input  logic                          gpu_ci_ready,
   input  logic                          gpu_ci_rsp_valid,
   input  logic [GPU_DATA_W-1:0]         gpu_ci_rsp_data,
   output logic                          gpu_ci_rsp_ready,
   output logic                          busy,
   output logic [IDX_W-1:0]              owner,
   output logic [7:0]                    stale_cnt,
   output logic                          timeout_flag
);

   // The wait counter is 16 bits wide; a budget it cannot count to is a build error.
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
      $error("gpu_ci_arbiter: TIMEOUT_CYCLES must be in 1..65536");
   end

   arb_state_t              state_reg;
   logic [IDX_W-1:0]        rr_ptr_reg;
   logic [IDX_W-1:0]        owner_reg;
   logic [GPU_OP_W-1:0]     op_reg;
   logic [GPU_DATA_W-1:0]   arg0_reg;
   logic [GPU_DATA_W-1:0]   arg1_reg;
   logic [GPU_DATA_W-1:0]   data_reg;
   logic [7:0]              stale_cnt_reg;

   logic [N_REQ-1:0]        pick_grant;
   logic [IDX_W-1:0]        pick_idx;
   logic                    pick_any;
   logic [IDX_W-1:0]        rr_ptr_next;
   logic [GPU_OP_W-1:0]     pick_op;
   logic [GPU_DATA_W-1:0]   pick_arg0;
   logic [GPU_DATA_W-1:0]   pick_arg1;
   logic                    rsp_ack;
   logic                    timeout_hit;

   gpu_ci_rr_pick #(
      .N_REQ  (N_REQ)
   ) u_pick (
      .req    (req_valid),
      .rr_ptr (rr_ptr_reg),
      .grant  (pick_grant),
      .idx    (pick_idx),
      .any    (pick_any)
   );

   assign rr_ptr_next = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;

   // Mux the winning hart's command; pick_grant is one-hot or zero.
   always_comb begin
      pick_op   = '0;
      pick_arg0 = '0;
      pick_arg1 = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (pick_grant[i]) begin
            pick_op   = req_op[i*GPU_OP_W +: GPU_OP_W];
            pick_arg0 = req_arg0[i*GPU_DATA_W +: GPU_DATA_W];
            pick_arg1 = req_arg1[i*GPU_DATA_W +: GPU_DATA_W];
         end
      end
   end

   for (genvar gi = 0; gi < N_REQ; gi++) begin : g_hart
      assign req_ready[gi]     = (state_reg == IDLE) && pick_grant[gi];
      assign req_rsp_valid[gi] = (state_reg == RETURN) && (owner_reg == IDX_W'(gi));
   end

   assign rsp_ack = |(req_rsp_valid & req_rsp_ready);

`ifdef GPU_CI_ARB_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] wait_cnt_reg;
   logic        timeout_flag_reg;

   // A real response in the final cycle still wins over the timeout.
   assign timeout_hit = (state_reg == WAIT_RSP) && !gpu_ci_rsp_valid &&
                        (wait_cnt_reg == TIMEOUT_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt_reg     <= '0;
         timeout_flag_reg <= 1'b0;
      end else begin
         if (state_reg == ISSUE && gpu_ci_ready) begin
            wait_cnt_reg <= '0;
         end else if (state_reg == WAIT_RSP) begin
            wait_cnt_reg <= wait_cnt_reg + 16'd1;
         end
         if (timeout_hit) begin
            timeout_flag_reg <= 1'b1;
         end
      end
   end

   assign timeout_flag = timeout_flag_reg;
`else
   assign timeout_hit  = 1'b0;
   assign timeout_flag = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         rr_ptr_reg    <= '0;
         owner_reg     <= '0;
         op_reg        <= '0;
         arg0_reg      <= '0;
         arg1_reg      <= '0;
         data_reg      <= '0;
         stale_cnt_reg <= '0;
      end else begin
         // Nobody is waiting for a response in IDLE/ISSUE: drop it and count it.
         if (gpu_ci_rsp_valid && (state_reg == IDLE || state_reg == ISSUE) &&
             stale_cnt_reg != 8'hFF) begin
            stale_cnt_reg <= stale_cnt_reg + 8'd1;
         end
         case (state_reg)
            IDLE: begin
               if (pick_any) begin
                  owner_reg  <= pick_idx;
                  op_reg     <= pick_op;
                  arg0_reg   <= pick_arg0;
                  arg1_reg   <= pick_arg1;
                  rr_ptr_reg <= rr_ptr_next;
                  state_reg  <= ISSUE;
               end
            end
            ISSUE: begin
               if (gpu_ci_ready) begin
                  state_reg <= WAIT_RSP;
               end
            end
            WAIT_RSP: begin
               if (gpu_ci_rsp_valid || timeout_hit) begin
                  data_reg  <= gpu_ci_rsp_valid ? gpu_ci_rsp_data : ERR_DATA;
                  state_reg <= RETURN;
               end
            end
            RETURN: begin
               if (rsp_ack) begin
                  state_reg <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign gpu_ci_valid     = (state_reg == ISSUE);
   assign gpu_ci_op        = op_reg;
   assign gpu_ci_arg0      = arg0_reg;
   assign gpu_ci_arg1      = arg1_reg;
   assign gpu_ci_rsp_ready = (state_reg != RETURN);
   assign req_rsp_data     = data_reg;
   assign busy             = (state_reg != IDLE);
   assign owner            = owner_reg;
   assign stale_cnt        = stale_cnt_reg;

endmodule

// File: tb/tb_gpu_ci_arbiter.sv
// tb_gpu_ci_arbiter
//   Self-checking bench for gpu_ci_arbiter with N_REQ=4, TIMEOUT_CYCLES=16.
//   Hand sequences cover latency, stale responses, reset during WAIT_RSP and
//   the timeout path; a table drives round-robin snapshots; a random phase
//   checks grants and routing against a transaction-level model.
module tb_gpu_ci_arbiter;

   localparam int N = 4;
   localparam logic [63:0] ERR = 64'hDEAD_0BAD_DEAD_0BAD;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  req_valid;
   logic [8*N-1:0]  req_op;
   logic [64*N-1:0] req_arg0;
   logic [64*N-1:0] req_arg1;
   logic [N-1:0]  req_ready;
   logic [N-1:0]  req_rsp_valid;
   logic [63:0]   req_rsp_data;
   logic [N-1:0]  req_rsp_ready;
   logic          gpu_ci_valid;
   logic [7:0]    gpu_ci_op;
   logic [63:0]   gpu_ci_arg0;
   logic [63:0]   gpu_ci_arg1;
   logic          gpu_ci_ready;
   logic          gpu_ci_rsp_valid;
   logic [63:0]   gpu_ci_rsp_data;
   logic          gpu_ci_rsp_ready;
   logic          busy;
   logic [1:0]    owner;
   logic [7:0]    stale_cnt;
   logic          timeout_flag;

   int total = 0;
   int bad   = 0;

   logic [7:0]  hop [N];
   logic [63:0] ha0 [N];
   logic [63:0] ha1 [N];

   typedef struct {
      logic [3:0]  reqv;
      int          win;
      logic [7:0]  op;
      logic [63:0] rsp;
   } vec_t;

   vec_t tbl [8];

   always #5 clk = ~clk;

   gpu_ci_arbiter #(
      .N_REQ          (N),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .req_valid        (req_valid),
      .req_op           (req_op),
      .req_arg0         (req_arg0),
      .req_arg1         (req_arg1),
      .req_ready        (req_ready),
      .req_rsp_valid    (req_rsp_valid),
      .req_rsp_data     (req_rsp_data),
      .req_rsp_ready    (req_rsp_ready),
      .gpu_ci_valid     (gpu_ci_valid),
      .gpu_ci_op        (gpu_ci_op),
      .gpu_ci_arg0      (gpu_ci_arg0),
      .gpu_ci_arg1      (gpu_ci_arg1),
      .gpu_ci_ready     (gpu_ci_ready),
      .gpu_ci_rsp_valid (gpu_ci_rsp_valid),
      .gpu_ci_rsp_data  (gpu_ci_rsp_data),
      .gpu_ci_rsp_ready (gpu_ci_rsp_ready),
      .busy             (busy),
      .owner            (owner),
      .stale_cnt        (stale_cnt),
      .timeout_flag     (timeout_flag)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Move to 1 time unit after the next rising edge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_bus();
      for (int i = 0; i < N; i++) begin
         req_op[8*i +: 8]    = hop[i];
         req_arg0[64*i +: 64] = ha0[i];
         req_arg1[64*i +: 64] = ha1[i];
      end
   endtask

   task automatic quiet_inputs();
      req_valid        = '0;
      req_rsp_ready    = '0;
      gpu_ci_ready     = 1'b0;
      gpu_ci_rsp_valid = 1'b0;
      gpu_ci_rsp_data  = '0;
   endtask

   task automatic do_reset();
      quiet_inputs();
      rst_n = 1'b0;
      cyc();
      rst_n = 1'b1;
   endtask

   // Round-robin rule from the behaviour description: first pending hart
   // found scanning ptr, ptr+1, ... modulo N.
   function automatic int model_pick(input logic [3:0] pend, input int ptr);
      for (int d = 0; d < N; d++) begin
         if (pend[(ptr + d) % N]) return (ptr + d) % N;
      end
      return -1;
   endfunction

   // One full command from the IDLE grant cycle back to IDLE. Losing harts
   // keep requesting throughout; the caller decides what they do afterwards.
   task automatic run_txn(input logic [3:0] reqv, input int w, input logic [63:0] rsp,
                          input int issue_wait, input int rsp_wait, input int ack_wait);
      logic [3:0] oh;
      oh = 4'b0001 << w;
      drive_bus();
      req_valid = reqv;
      gpu_ci_ready = 1'b0;
      gpu_ci_rsp_valid = 1'b0;
      req_rsp_ready = '0;
      #2;
      chk("grant", req_ready, oh);
      cyc();
      req_valid = reqv & ~oh;
      for (int k = 0; k < issue_wait; k++) begin
         #2;
         chk("issue_hold_valid", gpu_ci_valid, 1);
         chk("issue_hold_op", gpu_ci_op, hop[w]);
         chk("issue_hold_arg0", gpu_ci_arg0, ha0[w]);
         chk("issue_no_ready", req_ready, 0);
         cyc();
      end
      gpu_ci_ready = 1'b1;
      #2;
      chk("issue_valid", gpu_ci_valid, 1);
      chk("issue_op", gpu_ci_op, hop[w]);
      chk("issue_arg0", gpu_ci_arg0, ha0[w]);
      chk("issue_arg1", gpu_ci_arg1, ha1[w]);
      chk("issue_owner", owner, w);
      cyc();
      gpu_ci_ready = 1'b0;
      for (int k = 0; k < rsp_wait; k++) begin
         #2;
         chk("wait_busy", busy, 1);
         chk("wait_no_rsp", req_rsp_valid, 0);
         cyc();
      end
      gpu_ci_rsp_valid = 1'b1;
      gpu_ci_rsp_data  = rsp;
      #2;
      chk("wait_rsp_ready", gpu_ci_rsp_ready, 1);
      cyc();
      gpu_ci_rsp_valid = 1'b0;
      for (int k = 0; k < ack_wait; k++) begin
         #2;
         chk("ret_hold_valid", req_rsp_valid, oh);
         cyc();
      end
      req_rsp_ready = oh;
      #2;
      chk("ret_valid", req_rsp_valid, oh);
      chk("ret_data", req_rsp_data, rsp);
      chk("ret_gpu_rsp_ready", gpu_ci_rsp_ready, 0);
      cyc();
      req_rsp_ready = '0;
      #2;
      chk("done_idle", busy, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [3:0] pend;
      int         mptr;
      int         w;

      for (int i = 0; i < N; i++) begin
         hop[i] = '0;
         ha0[i] = '0;
         ha1[i] = '0;
      end
      drive_bus();
      quiet_inputs();
      rst_n = 1'b0;

      tbl[0] = '{4'b0001, 0, 8'h21, 64'h1111};
      tbl[1] = '{4'b0001, 0, 8'h32, 64'h2222};
      tbl[2] = '{4'b1001, 3, 8'h43, 64'h3333};
      tbl[3] = '{4'b1010, 1, 8'h54, 64'h4444};
      tbl[4] = '{4'b0011, 0, 8'h65, 64'h5555};
      tbl[5] = '{4'b1111, 1, 8'h76, 64'h6666};
      tbl[6] = '{4'b0100, 2, 8'h87, 64'h7777};
      tbl[7] = '{4'b0110, 1, 8'h98, 64'h8888};

      // Reset values
      cyc();
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_gpu_valid", gpu_ci_valid, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_rsp_valid", req_rsp_valid, 0);
      chk("rst_stale", stale_cnt, 0);
      chk("rst_timeout", timeout_flag, 0);
      chk("rst_owner", owner, 0);
      chk("rst_op", gpu_ci_op, 0);
      chk("rst_arg0", gpu_ci_arg0, 0);
      chk("rst_data", req_rsp_data, 0);
      cyc();
      rst_n = 1'b1;

      // Minimum latency: hart 2, op 15, response 42
      hop[2] = 8'h15; ha0[2] = 64'd1; ha1[2] = 64'd2;
      drive_bus();
      req_valid = 4'b0100;
      gpu_ci_ready = 1'b1;
      #2;
      chk("lat_t0_ready", req_ready, 4'b0100);
      cyc();
      req_valid = '0;
      #2;
      chk("lat_t1_valid", gpu_ci_valid, 1);
      chk("lat_t1_op", gpu_ci_op, 8'h15);
      chk("lat_t1_arg0", gpu_ci_arg0, 1);
      chk("lat_t1_arg1", gpu_ci_arg1, 2);
      cyc();
      gpu_ci_ready = 1'b0;
      gpu_ci_rsp_valid = 1'b1;
      gpu_ci_rsp_data = 64'h42;
      #2;
      chk("lat_t2_busy", busy, 1);
      chk("lat_t2_valid", gpu_ci_valid, 0);
      cyc();
      gpu_ci_rsp_valid = 1'b0;
      req_rsp_ready = 4'b0100;
      #2;
      chk("lat_t3_rsp_valid", req_rsp_valid, 4'b0100);
      chk("lat_t3_rsp_data", req_rsp_data, 64'h42);
      chk("lat_t3_gpu_rsp_ready", gpu_ci_rsp_ready, 0);
      cyc();
      req_rsp_ready = '0;
      #2;
      chk("lat_t4_busy", busy, 0);
      chk("lat_t4_rsp_valid", req_rsp_valid, 0);

      // Stale responses while IDLE
      cyc();
      gpu_ci_rsp_valid = 1'b1;
      gpu_ci_rsp_data = 64'hBAD;
      cyc();
      gpu_ci_rsp_valid = 1'b0;
      #2;
      chk("stale_one", stale_cnt, 1);
      chk("stale_no_rsp", req_rsp_valid, 0);
      chk("stale_idle", busy, 0);
      gpu_ci_rsp_valid = 1'b1;
      repeat (300) cyc();
      gpu_ci_rsp_valid = 1'b0;
      #2;
      chk("stale_sat", stale_cnt, 255);

      // Reset while in WAIT_RSP (rr pointer is 3, only hart 1 asks)
      cyc();
      hop[1] = 8'h5A; ha0[1] = 64'hABCD; ha1[1] = 64'h1234;
      drive_bus();
      req_valid = 4'b0010;
      cyc();
      req_valid = '0;
      gpu_ci_ready = 1'b1;
      cyc();
      gpu_ci_ready = 1'b0;
      cyc();
      #2;
      chk("rstw_pre_busy", busy, 1);
      chk("rstw_pre_owner", owner, 1);
      rst_n = 1'b0;
      #1;
      chk("rstw_busy", busy, 0);
      chk("rstw_gpu_valid", gpu_ci_valid, 0);
      chk("rstw_rsp_valid", req_rsp_valid, 0);
      chk("rstw_stale", stale_cnt, 0);
      chk("rstw_owner", owner, 0);
      chk("rstw_op", gpu_ci_op, 0);
      cyc();
      rst_n = 1'b1;
      gpu_ci_rsp_valid = 1'b1;
      gpu_ci_rsp_data = 64'h77;
      cyc();
      gpu_ci_rsp_valid = 1'b0;
      #2;
      chk("rstw_late_stale", stale_cnt, 1);
      chk("rstw_late_no_rsp", req_rsp_valid, 0);

      // All four harts held from rr_ptr=0: order 0,1,2,3,0; first grant
      // stalls 5 cycles in ISSUE.
      for (int i = 0; i < N; i++) begin
         hop[i] = 8'hC0 + 8'(i); ha0[i] = 64'(i) * 64'h100; ha1[i] = 64'(i) + 64'h9;
      end
      run_txn(4'b1111, 0, 64'hA0, 5, 0, 0);
      run_txn(4'b1111, 1, 64'hA1, 0, 1, 1);
      run_txn(4'b1111, 2, 64'hA2, 1, 2, 0);
      run_txn(4'b1111, 3, 64'hA3, 0, 0, 2);
      run_txn(4'b1111, 0, 64'hA4, 2, 0, 0);
      req_valid = '0;

      // Table of request snapshots from rr_ptr=0
      do_reset();
      for (int e = 0; e < 8; e++) begin
         for (int i = 0; i < N; i++) begin
            hop[i] = tbl[e].op + 8'(i);
            ha0[i] = {56'h0, tbl[e].op} + 64'(i);
            ha1[i] = tbl[e].rsp ^ 64'(i);
         end
         run_txn(tbl[e].reqv, tbl[e].win, tbl[e].rsp, e % 3, e % 2, (e + 1) % 3);
         req_valid = '0;
      end

      // WAIT_RSP with no response (rr pointer is 2, hart 3 asks)
      cyc();
      hop[3] = 8'hEE; drive_bus();
      req_valid = 4'b1000;
      cyc();
      req_valid = '0;
      gpu_ci_ready = 1'b1;
      cyc();
      gpu_ci_ready = 1'b0;
`ifdef GPU_CI_ARB_TIMEOUT_EN
      for (int k = 0; k < 15; k++) begin
         #2;
         chk("to_wait_no_rsp", req_rsp_valid, 0);
         chk("to_wait_flag", timeout_flag, 0);
         cyc();
      end
      #2;
      chk("to_last_no_rsp", req_rsp_valid, 0);
      cyc();
      #2;
      chk("to_rsp_valid", req_rsp_valid, 4'b1000);
      chk("to_rsp_data", req_rsp_data, ERR);
      chk("to_flag", timeout_flag, 1);
      req_rsp_ready = 4'b1000;
      cyc();
      req_rsp_ready = '0;
      cyc();
      #2;
      chk("to_flag_sticky", timeout_flag, 1);
      chk("to_idle", busy, 0);
`else
      repeat (10000) cyc();
      #2;
      chk("nto_busy", busy, 1);
      chk("nto_gpu_valid", gpu_ci_valid, 0);
      chk("nto_rsp_valid", req_rsp_valid, 0);
      chk("nto_gpu_rsp_ready", gpu_ci_rsp_ready, 1);
      chk("nto_flag", timeout_flag, 0);
`endif

      // Random traffic against the transaction-level model
      do_reset();
      pend = '0;
      mptr = 0;
      for (int t = 0; t < 40; t++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
               pend[i] = 1'b1;
               hop[i] = 8'($urandom);
               ha0[i] = {$urandom, $urandom};
               ha1[i] = {$urandom, $urandom};
            end
         end
         if (pend == '0) begin
            w = $urandom_range(0, N - 1);
            pend[w] = 1'b1;
            hop[w] = 8'($urandom);
            ha0[w] = {$urandom, $urandom};
            ha1[w] = {$urandom, $urandom};
         end
         w = model_pick(pend, mptr);
         run_txn(pend, w, {$urandom, $urandom}, $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3));
         pend[w] = 1'b0;
         mptr = (w + 1) % N;
      end
      req_valid = '0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
